// File: rtl/ysyx_22040088_lsu_pkg.sv
// ============================================================================
// Module   : ysyx_22040088_lsu_pkg
// Brief    : Shared size-mask, load-extension and state encodings for the LSU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ysyx_22040088_lsu_pkg;

   localparam logic [3:0] MASK_D = 4'b0001;
   localparam logic [3:0] MASK_W = 4'b0010;
   localparam logic [3:0] MASK_H = 4'b0100;
   localparam logic [3:0] MASK_B = 4'b1000;

   localparam int SEL_SIGN = 0;
   localparam int SEL_ZERO = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   // Byte-lane strobe for an access of the given size at offset zero.
   function automatic logic [7:0] size_strobe(input logic [3:0] mask);
      logic [7:0] strb;
      case (mask)
         MASK_D:  strb = 8'hFF;
         MASK_W:  strb = 8'h0F;
         MASK_H:  strb = 8'h03;
         MASK_B:  strb = 8'h01;
         default: strb = 8'h00;
      endcase
      return strb;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040088_lsu_align.sv
// ============================================================================
// Module   : ysyx_22040088_lsu_align
// Brief    : Store lane shift/strobe generation and load extract/extend.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040088_lsu_align
   import ysyx_22040088_lsu_pkg::*;
(
   input  logic [2:0]  st_off,
   input  logic [3:0]  st_mask,
   input  logic [63:0] st_wdata,
   output logic [63:0] st_wdata_sh,
   output logic [7:0]  st_wstrb,
   input  logic [2:0]  ld_off,
   input  logic [3:0]  ld_mask,
   input  logic [1:0]  ld_sel,
   input  logic [63:0] ld_rdata,
   output logic [63:0] ld_data
);

   logic [63:0] w_ld_sh;
   logic        w_sign;

   always_comb begin
      st_wdata_sh = st_wdata << {st_off, 3'b000};
      st_wstrb    = size_strobe(st_mask) << st_off;
      w_ld_sh     = ld_rdata >> {ld_off, 3'b000};
      w_sign      = ld_sel[SEL_SIGN] & ~ld_sel[SEL_ZERO];
      case (ld_mask)
         MASK_W:  ld_data = {{32{w_sign & w_ld_sh[31]}}, w_ld_sh[31:0]};
         MASK_H:  ld_data = {{48{w_sign & w_ld_sh[15]}}, w_ld_sh[15:0]};
         MASK_B:  ld_data = {{56{w_sign & w_ld_sh[7]}},  w_ld_sh[7:0]};
         default: ld_data = w_ld_sh;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040088_lsu.sv
// ============================================================================
// Module   : ysyx_22040088_lsu
// Brief    : Load/store unit: one 64-bit bus transaction per memory op.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040088_lsu
   import ysyx_22040088_lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_wen,
   input  logic [3:0]  in_mask,
   input  logic [1:0]  in_sel_memdata,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_wen,
   output logic [63:0] req_addr,
   output logic [63:0] req_wdata,
   output logic [7:0]  req_wstrb,
   input  logic        rsp_valid,
   input  logic [63:0] rsp_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_err
);

   localparam logic [7:0] c_timeout = 8'(TIMEOUT);

   lsu_state_e  r_state;
   lsu_state_e  w_state_next;
   logic        r_wen;
   logic [3:0]  r_mask;
   logic [1:0]  r_sel;
   logic [2:0]  r_off;
   logic [7:0]  r_tmo;

   logic        w_mask_ok;
   logic        w_sel_ok;
   logic        w_align_ok;
   logic        w_legal;
   logic        w_tmo_hit;
   logic [63:0] w_st_wdata;
   logic [7:0]  w_st_wstrb;
   logic [63:0] w_ld_data;

   ysyx_22040088_lsu_align u_align (
      .st_off      (in_addr[2:0]),
      .st_mask     (in_mask),
      .st_wdata    (in_wdata),
      .st_wdata_sh (w_st_wdata),
      .st_wstrb    (w_st_wstrb),
      .ld_off      (r_off),
      .ld_mask     (r_mask),
      .ld_sel      (r_sel),
      .ld_rdata    (rsp_rdata),
      .ld_data     (w_ld_data)
   );

   // Doubleword loads need no extension, so any non-zero selector is taken.
   always_comb begin
      w_mask_ok  = 1'b1;
      w_align_ok = 1'b0;
      case (in_mask)
         MASK_D:  w_align_ok = (in_addr[2:0] == 3'b000);
         MASK_W:  w_align_ok = (in_addr[1:0] == 2'b00);
         MASK_H:  w_align_ok = ~in_addr[0];
         MASK_B:  w_align_ok = 1'b1;
         default: w_mask_ok  = 1'b0;
      endcase
      if (in_wen)
         w_sel_ok = 1'b1;
      else if (in_mask == MASK_D)
         w_sel_ok = (in_sel_memdata != 2'b00);
      else
         w_sel_ok = (in_sel_memdata == 2'b01) || (in_sel_memdata == 2'b10);
      w_legal   = w_mask_ok & w_align_ok & w_sel_ok;
      w_tmo_hit = ((r_tmo + 8'd1) == c_timeout);
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_next = w_legal ? S_REQ : S_DONE;
         S_REQ:  if (req_ready) w_state_next = S_RSP;
         S_RSP:  if (rsp_valid || w_tmo_hit) w_state_next = S_DONE;
         S_DONE: if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         in_ready  <= 1'b1;
         req_valid <= 1'b0;
         out_valid <= 1'b0;
         req_wen   <= 1'b0;
         req_addr  <= 64'd0;
         req_wdata <= 64'd0;
         req_wstrb <= 8'd0;
         out_rdata <= 64'd0;
         out_rd    <= 5'd0;
         out_err   <= 1'b0;
         r_wen     <= 1'b0;
         r_mask    <= 4'd0;
         r_sel     <= 2'd0;
         r_off     <= 3'd0;
         r_tmo     <= 8'd0;
      end else begin
         r_state   <= w_state_next;
         in_ready  <= (w_state_next == S_IDLE);
         req_valid <= (w_state_next == S_REQ);
         out_valid <= (w_state_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_wen     <= in_wen;
                  r_mask    <= in_mask;
                  r_sel     <= in_sel_memdata;
                  r_off     <= in_addr[2:0];
                  out_rd    <= in_rd;
                  out_rdata <= 64'd0;
                  out_err   <= ~w_legal;
                  if (w_legal) begin
                     req_wen   <= in_wen;
                     req_addr  <= {in_addr[63:3], 3'b000};
                     req_wdata <= in_wen ? w_st_wdata : 64'd0;
                     req_wstrb <= in_wen ? w_st_wstrb : 8'd0;
                  end
               end
            end
            S_REQ: begin
               if (req_ready) r_tmo <= 8'd0;
            end
            S_RSP: begin
               if (rsp_valid)
                  out_rdata <= r_wen ? 64'd0 : w_ld_data;
               else if (w_tmo_hit)
                  out_err <= 1'b1;
               else
                  r_tmo <= r_tmo + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040088_lsu.sv
// ============================================================================
// Module   : tb_ysyx_22040088_lsu
// Brief    : Directed plus randomized check of the LSU against a byte-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22040088_lsu;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, in_wen = 1'b0;
   logic [3:0]  in_mask = 4'd0;
   logic [1:0]  in_sel_memdata = 2'd0;
   logic [63:0] in_addr = 64'd0, in_wdata = 64'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        req_valid, req_ready = 1'b0, req_wen;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid = 1'b0;
   logic [63:0] rsp_rdata = 64'd0;
   logic        out_valid, out_ready = 1'b0;
   logic [63:0] out_rdata;
   logic [4:0]  out_rd;
   logic        out_err;

   int total = 0;
   int bad   = 0;

   logic [63:0] o_wdata, o_rdata;
   logic [7:0]  o_wstrb;
   logic        o_err, o_reqv;
   int          o_lat;

   ysyx_22040088_lsu #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_mask(in_mask),
      .in_sel_memdata(in_sel_memdata), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_rd(out_rd), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access size in bytes, 0 when the mask is not a legal size.
   function automatic int m_size(input logic [3:0] m);
      case (m)
         4'b0001: return 8;
         4'b0010: return 4;
         4'b0100: return 2;
         4'b1000: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_legal(input logic wen, input logic [3:0] m, input logic [1:0] s,
                                  input logic [63:0] a);
      int n = m_size(m);
      if (n == 0) return 0;
      if ((a % n) != 0) return 0;
      if (wen) return 1;
      if (n == 8) return s != 2'b00;
      return (s == 2'b01) || (s == 2'b10);
   endfunction

   function automatic logic [63:0] m_load(input logic [3:0] m, input logic [1:0] s,
                                          input logic [63:0] a, input logic [63:0] d);
      int n = m_size(m);
      logic [127:0] v, lim;
      v   = {64'd0, d} >> (8 * (a % 8));
      lim = (128'd1 << (8 * n)) - 128'd1;
      v   = v & lim;
      if (s == 2'b01 && n < 8 && v[8*n-1]) v = v | ~lim;
      return v[63:0];
   endfunction

   task automatic do_op(input logic wen, input logic [3:0] m, input logic [1:0] s,
                        input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] rdata, input int req_stall, input int rsp_dly,
                        input bit no_rsp, input int out_stall);
      bit          legal = m_legal(wen, m, s, a);
      int          n = m_size(m);
      logic [63:0] e_wdata, e_rdata;
      logic [15:0] e_strb16;
      logic [63:0] held;
      int          k;
      e_strb16 = 16'((17'd1 << n) - 17'd1) << (a % 8);
      e_wdata  = wen ? (wd << (8 * (a % 8))) : 64'd0;
      e_rdata  = (!legal || wen || no_rsp) ? 64'd0 : m_load(m, s, a, rdata);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_wen = wen; in_mask = m; in_sel_memdata = s;
      in_addr = a; in_wdata = wd; in_rd = rd;
      tick();
      in_valid = 1'b0;
      o_lat  = 1;
      o_reqv = req_valid;
      if (!legal) begin
         chk("err_no_req", 64'(req_valid), 64'd0);
         chk("err_out_valid", 64'(out_valid), 64'd1);
      end else begin
         chk("req_valid", 64'(req_valid), 64'd1);
         chk("req_addr", req_addr, {a[63:3], 3'b000});
         chk("req_wen", 64'(req_wen), 64'(wen));
         chk("req_wstrb", 64'(req_wstrb), wen ? 64'(e_strb16[7:0]) : 64'd0);
         chk("req_wdata", req_wdata, e_wdata);
         o_wdata = req_wdata;
         o_wstrb = req_wstrb;
         for (int i = 0; i < req_stall; i++) begin
            tick(); o_lat++;
            chk("req_hold_valid", 64'(req_valid), 64'd1);
            chk("req_hold_wdata", req_wdata, e_wdata);
            chk("req_hold_addr", req_addr, {a[63:3], 3'b000});
         end
         req_ready = 1'b1;
         tick(); o_lat++;
         req_ready = 1'b0;
         if (no_rsp) begin
            k = 0;
            while (!out_valid && k <= 300) begin
               tick(); k++; o_lat++;
            end
            chk("timeout_cycles", 64'(k), 64'(TMO));
         end else begin
            for (int i = 0; i < rsp_dly; i++) begin
               tick(); o_lat++;
            end
            rsp_valid = 1'b1; rsp_rdata = rdata;
            tick(); o_lat++;
            rsp_valid = 1'b0; rsp_rdata = $urandom;
         end
      end
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_err", 64'(out_err), 64'(!legal || no_rsp));
      chk("out_rdata", out_rdata, e_rdata);
      chk("out_rd", 64'(out_rd), 64'(rd));
      o_err   = out_err;
      o_rdata = out_rdata;
      held    = out_rdata;
      for (int i = 0; i < out_stall; i++) begin
         tick();
         chk("out_hold_valid", 64'(out_valid), 64'd1);
         chk("out_hold_in_ready", 64'(in_ready), 64'd0);
         chk("out_hold_rdata", out_rdata, held);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("back_idle_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic        wen;
      logic [3:0]  m;
      logic [1:0]  s;
      logic [63:0] a;
      int          n;
      tick();
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_req_addr", req_addr, 64'd0);
      chk("rst_out_rdata", out_rdata, 64'd0);
      rst = 1'b0;
      tick();

      // sb at offset 5 over a zero-wait bus
      do_op(1'b1, 4'b1000, 2'b00, 64'h8000_0005, 64'hAB, 5'd3, 64'd0, 0, 0, 0, 0);
      chk("sb_wstrb", 64'(o_wstrb), 64'h20);
      chk("sb_wdata", o_wdata, 64'h0000_AB00_0000_0000);
      chk("sb_latency", 64'(o_lat), 64'd3);

      do_op(1'b0, 4'b0100, 2'b01, 64'h8000_1002, 64'd0, 5'd7, 64'h0000_0000_8001_0000, 0, 1, 0, 0);
      chk("lh_value", o_rdata, 64'hFFFF_FFFF_FFFF_8001);
      do_op(1'b0, 4'b0100, 2'b10, 64'h8000_1002, 64'd0, 5'd7, 64'h0000_0000_8001_0000, 0, 0, 0, 0);
      chk("lhu_value", o_rdata, 64'h0000_0000_0000_8001);

      do_op(1'b0, 4'b0010, 2'b01, 64'h8000_0006, 64'd0, 5'd9, 64'd0, 0, 0, 0, 0);
      chk("lw_mis_err", 64'(o_err), 64'd1);
      chk("lw_mis_noreq", 64'(o_reqv), 64'd0);

      do_op(1'b0, 4'b0001, 2'b01, 64'h8000_0010, 64'd0, 5'd1, 64'd0, 5, 0, 1, 0);
      do_op(1'b0, 4'b0010, 2'b10, 64'h8000_0024, 64'd0, 5'd4, 64'hDEAD_BEEF_1234_5678, 1, 2, 0, 4);

      // Reset while waiting for the response, then a stray response.
      in_valid = 1'b1; in_wen = 1'b0; in_mask = 4'b0001; in_sel_memdata = 2'b01;
      in_addr = 64'h100; in_rd = 5'd12;
      tick();
      in_valid = 1'b0; req_ready = 1'b1;
      tick();
      req_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
      chk("mid_rst_req_addr", req_addr, 64'd0);
      chk("mid_rst_out_rd", 64'(out_rd), 64'd0);
      rsp_valid = 1'b1; rsp_rdata = 64'h1111;
      tick();
      rsp_valid = 1'b0;
      chk("stray_out_valid", 64'(out_valid), 64'd0);
      chk("stray_out_rdata", out_rdata, 64'd0);
      do_op(1'b0, 4'b1000, 2'b01, 64'h203, 64'd0, 5'd2, 64'h0000_0000_F000_0000, 0, 0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         wen = 1'($urandom_range(0, 1));
         m = ($urandom_range(0, 9) < 9) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
         s = ($urandom_range(0, 4) == 0) ? 2'($urandom) : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
         if (!wen && m == 4'b0001 && (s == 2'b00 || s == 2'b11)) s = 2'b10;
         a = {$urandom, $urandom};
         n = m_size(m);
         if (n != 0 && $urandom_range(0, 3) != 0) a = a - (a % n);
         do_op(wen, m, s, a, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
               $urandom_range(0, 2), $urandom_range(0, 5), 1'b0, $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
